// File: rtl/battery_manager.sv
// battery_manager: tracks a 2-bit battery level that drains with fan activity and
// recovers one step per charge-button press.
//
// A free-running prescaler produces a one-cycle tick every TICK_DIV clocks. On each
// tick the current fan_state (0..3) is added to a drain accumulator. When the
// accumulator reaches DRAIN_PER_LEVEL, the level drops one step and the remainder
// is carried over. A charge press raises the level one step and clears the
// accumulator. The press wins over a coincident tick.
//
// Optional feature: define BATTERY_LOW_WARN_EN to build the low-battery blinker.
// While level is 01, low_warn toggles every BLINK_DIV clocks. Without the macro,
// low_warn is tied to 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   fan_state[1:0] fan speed: 00 off, 01 low, 10 mid, 11 high
//   charge_press   single-cycle charge pulse
//   level[1:0]     battery level, 00 empty .. 11 full (registered)
//   battery_empty  registered, equals (level == 00)
//   low_warn       registered low-battery blink output
module battery_manager #(
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned DRAIN_PER_LEVEL = 30,
    parameter int unsigned BLINK_DIV       = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] fan_state,
    input  logic       charge_press,
    output logic [1:0] level,
    output logic       battery_empty,
    output logic       low_warn
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // The sum of a stored remainder (< DRAIN_PER_LEVEL) and fan_state can reach
    // DRAIN_PER_LEVEL+2.
    localparam int unsigned AW = $clog2(DRAIN_PER_LEVEL + 3);

    // Elaboration-time parameter sanity checks.
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be >= 2");
    end
    if (DRAIN_PER_LEVEL < 4) begin : g_bad_drain
        $error("DRAIN_PER_LEVEL must be >= 4");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("BLINK_DIV must be >= 2");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acc_q, acc_d, sum;
    logic [1:0]    level_q, level_d;
    logic          empty_q;
    logic          tick;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        level_d = level_q;
        acc_d   = acc_q;
        sum     = acc_q + AW'(fan_state);

        if (charge_press && (level_q != 2'b11)) begin
            level_d = level_q + 2'd1;
            acc_d   = '0;
        end else if (tick) begin
            if (level_q == 2'b00) begin
                acc_d = '0;
            end else if (sum >= AW'(DRAIN_PER_LEVEL)) begin
                acc_d   = sum - AW'(DRAIN_PER_LEVEL);
                level_d = level_q - 2'd1;
            end else begin
                acc_d = sum;
            end
        end

        // An empty battery carries no partial drain.
        if (level_d == 2'b00) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            acc_q   <= '0;
            level_q <= 2'b11;
            empty_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            // Computed from level_d so both flops update on the same edge.
            empty_q <= (level_d == 2'b00);
        end
    end

    assign level         = level_q;
    assign battery_empty = empty_q;

`ifdef BATTERY_LOW_WARN_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_q, blink_d;
    logic          warn_q, warn_d;

    always_comb begin
        blink_d = '0;
        warn_d  = 1'b0;
        if (level_q == 2'b01) begin
            if (blink_q == BW'(BLINK_DIV - 1)) begin
                blink_d = '0;
                warn_d  = ~warn_q;
            end else begin
                blink_d = blink_q + BW'(1);
                warn_d  = warn_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
            warn_q  <= 1'b0;
        end else begin
            blink_q <= blink_d;
            warn_q  <= warn_d;
        end
    end

    assign low_warn = warn_q;
`else
    assign low_warn = 1'b0;
`endif

endmodule

// File: doc/battery_manager.md
BATTERY_MANAGER -- requirements
Module: battery_manager

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per drain tick (>=2).
REQ-002 SHALL have parameter DRAIN_PER_LEVEL, default 30, drain units consumed per level step (>=4).
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per low_warn half-period (>=2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port fan_state  input  2  current fan state from the fan state controller: 00 off, 01 low, 10 mid, 11 high.
REQ-007 SHALL have port charge_press  input  1  single-cycle debounced charge-button pulse.
REQ-008 SHALL have port level  output  2  battery level, 00 empty to 11 full, registered.
REQ-009 SHALL have port battery_empty  output  1  high when level==00, registered, feeds the fan state controller.
REQ-010 SHALL have port low_warn  output  1  low-battery indicator, registered.

Function
REQ-011 SHALL count clk cycles 0..TICK_DIV-1 in a free-running prescaler and assert an internal tick for one cycle when the count equals TICK_DIV-1, then wrap to 0.
REQ-012 SHALL, on a tick cycle with no charge_press, add fan_state (0..3) to a drain accumulator sized to hold DRAIN_PER_LEVEL+2 without overflow.
REQ-013 SHALL, when acc+fan_state >= DRAIN_PER_LEVEL on a tick, store acc+fan_state-DRAIN_PER_LEVEL and decrement level by one in the same cycle.
REQ-014 SHALL saturate level at 00: at level 00 no decrement occurs and the accumulator holds at 0.
REQ-015 SHALL, on charge_press with level<11, increment level by one and clear the accumulator to 0 in the same cycle.
REQ-016 SHALL ignore charge_press at level 11 (level and accumulator unchanged, tick accumulation proceeds normally).
REQ-017 SHALL give charge_press priority when it coincides with a tick: no drain is added that cycle, and the charge rule applies.
REQ-018 SHALL add nothing on a tick when fan_state==00; the accumulator holds.
REQ-019 SHALL update battery_empty on the same clock edge as level, so battery_empty==(level==00) at all times with zero-cycle skew.
REQ-020 SHALL keep the prescaler running regardless of charge_press, fan_state or level.
REQ-021 SHALL treat fan_state as sampled only on tick cycles; changes between ticks have no effect.

Reset
REQ-022 SHALL, while rst_n is low, force level=11, battery_empty=0, low_warn=0, accumulator=0, prescaler=0, blink counter=0.
REQ-023 SHALL abandon any partial drain or blink phase on reset assertion mid-operation; operation resumes from the reset values on the first clk edge after rst_n deasserts.

Configuration
REQ-024 SHALL compile the low-battery blink feature only when macro BATTERY_LOW_WARN_EN is defined.
REQ-025 SHALL, with BATTERY_LOW_WARN_EN defined, run a blink counter 0..BLINK_DIV-1 only while level==01 and toggle low_warn at each wrap; on leaving level 01, clear the counter and low_warn to 0 on the next edge.
REQ-026 SHALL, without BATTERY_LOW_WARN_EN, drive low_warn constantly 0 and instantiate no blink counter.

Verification (TICK_DIV=4, DRAIN_PER_LEVEL=6, BLINK_DIV=3)
REQ-027 SHALL cover: reset release, fan_state=11 held -> level 11->10 after 2 ticks (8 clk), 10->01 after 2 more ticks, 01->00 after 2 more; battery_empty rises on the same edge as level 00.
REQ-028 SHALL cover: fan_state=01 held from full -> level decrements every 6 ticks (24 clk); fan_state=00 for 40 clk -> level and accumulator unchanged.
REQ-029 SHALL cover: level 00, charge_press pulse -> level 01, battery_empty 0 next edge; charge_press at level 11 -> no change.
REQ-030 SHALL cover: charge_press coinciding with a tick that would decrement -> level+1, accumulator 0, no decrement.
REQ-031 SHALL cover, with BATTERY_LOW_WARN_EN: level 01 -> low_warn toggles every 3 clk; charge to 10 -> low_warn 0 next edge; without the macro, low_warn stays 0 throughout.
REQ-032 SHALL cover: rst_n asserted with accumulator at 5 and level 10 -> level 11, accumulator 0 immediately; after release, first decrement under fan_state=11 occurs after exactly 2 ticks.
